uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1736, clock cycles per serial bit; legal range 2..8191.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1, data_in holds a word to send.
REQ-008 SHALL have port data_in, input, DATA_BITS, word to send, LSB transmitted first.
REQ-009 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-010 SHALL have port tx_o, output, 1, serial line, idle high.
REQ-011 SHALL have port busy_o, output, 1, a frame is being shifted out (any state other than IDLE).
REQ-012 SHALL have port done_o, output, 1, single-cycle pulse marking the last cycle of the final stop bit.

Function
REQ-013 SHALL hold one word in a holding register (hold_full flag) in addition to the shift register, so a second word can be accepted while a frame is in flight.
REQ-014 SHALL drive in_ready = ~hold_full, combinationally, independent of in_valid.
REQ-015 SHALL accept a word on any rising edge where in_valid && in_ready: capture data_in into the holding register and set hold_full.
REQ-016 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY==0.
REQ-017 IDLE -> START on the edge after hold_full is seen set in IDLE; on that same edge, move the holding register into the shift register and clear hold_full.
REQ-018 START drives tx_o=0; DATA drives the current data bit, LSB first; PARITY drives the parity bit; STOP drives tx_o=1; IDLE drives tx_o=1.
REQ-019 Every bit SHALL last exactly CLKS_PER_BIT cycles, timed by a 13-bit cycle counter cleared at each bit boundary.
REQ-020 The bit index counter SHALL count 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP, clearing on state exit.
REQ-021 Parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity, computed on the shift-register contents.
REQ-022 Frame length SHALL be (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-023 done_o SHALL assert for exactly one cycle: the last cycle of the last stop bit.
REQ-024 Back-to-back: if hold_full is set when the final stop bit ends, STOP -> START SHALL occur directly, with no idle cycle between frames.
REQ-025 If hold_full is clear when the final stop bit ends, STOP -> IDLE.
REQ-026 A word accepted on the same edge that the final stop bit ends SHALL be treated as present (REQ-024 applies).
REQ-027 When the holding register is full, in_valid SHALL be ignored and the held word SHALL remain stable.
REQ-028 busy_o and in_ready SHALL be registered-state functions only, with no combinational path from in_valid to any output.

Reset
REQ-029 While rst=1: state=IDLE, tx_o=1, busy_o=0, done_o=0, in_ready=1, hold_full=0, all counters 0, shift and holding registers 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately without waiting for a clock edge, and SHALL discard any held word.
REQ-031 After rst deasserts, the first word SHALL be accepted no earlier than the first rising edge.

Verification
REQ-032 CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done_o pulses at cycle 40 of the frame; busy_o high for 40 cycles.
REQ-033 Same configuration with PARITY=1 -> parity bit 0 inserted after the data bits, 44-cycle frame; with PARITY=2 -> parity bit 1.
REQ-034 DATA_BITS=7, STOP_BITS=2; send 0x7F then 0x00 with in_valid held -> 0x00 accepted during the first frame; second start bit begins the cycle after the first done_o, no idle gap; in_ready low while held.
REQ-035 Assert rst during DATA bit 3 -> tx_o=1 and busy_o=0 within the reset cycle; held word discarded; no done_o; a fresh send after reset produces a correct full frame.
REQ-036 in_valid asserted on the exact edge the final stop bit ends (hold empty) -> word accepted, next START follows with no IDLE cycle.
REQ-037 Hold in_valid=1 with data changing while hold_full=1 -> only the first-captured value is transmitted; later values are ignored until in_ready returns high.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS data (LSB first),
// optional parity, 1 or 2 stop bits, one-word holding register.
module uart_tx_cfg #(
   parameter int CLKS_PER_BIT = 1736,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 in_ready,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_e;

   localparam logic [12:0] CNT_LAST  = 13'(CLKS_PER_BIT - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic        PAR_EN    = (PARITY != 0);
   localparam logic        PAR_ODD   = (PARITY == 2);

   state_e               state_q, state_d;
   logic [12:0]          cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;

   logic                 accept;
   logic                 bit_end;
   logic                 last_stop;
   logic [DATA_BITS-1:0] data_sel;

   assign accept    = in_valid && !hold_full_q;
   assign bit_end   = (cnt_q == CNT_LAST);
   assign last_stop = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);
   assign data_sel  = shift_q >> idx_q;

   assign in_ready = ~hold_full_q;
   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = last_stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = bit_end ? '0 : cnt_q + 13'd1;
      idx_d       = idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (accept) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (hold_full_q) begin
               state_d     = S_START;
               shift_d     = hold_q;
               hold_full_d = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = PAR_EN ? S_PAR : S_STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_PAR: begin
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end) begin
               if (idx_q == STOP_LAST) begin
                  idx_d = '0;
                  // a word arriving on this very edge chains directly
                  if (hold_full_q) begin
                     state_d     = S_START;
                     shift_d     = hold_q;
                     hold_full_d = 1'b0;
                  end else if (accept) begin
                     state_d     = S_START;
                     shift_d     = data_in;
                     hold_full_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_o = 1'b1;
      unique case (state_q)
         S_START: tx_o = 1'b0;
         S_DATA:  tx_o = data_sel[0];
         S_PAR:   tx_o = (^shift_q) ^ PAR_ODD;
         default: tx_o = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations checked cycle by cycle
// against a queue-of-line-levels model, plus directed frame vectors.
module tb_uart_tx_cfg;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] inv;
   logic [8:0] din [3];
   logic [2:0] rdy, tx, bsy, dn;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(inv[0]), .data_in(din[0][7:0]),
      .in_ready(rdy[0]), .tx_o(tx[0]), .busy_o(bsy[0]), .done_o(dn[0]));

   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(inv[1]), .data_in(din[1][6:0]),
      .in_ready(rdy[1]), .tx_o(tx[1]), .busy_o(bsy[1]), .done_o(dn[1]));

   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(inv[2]), .data_in(din[2][7:0]),
      .in_ready(rdy[2]), .tx_o(tx[2]), .busy_o(bsy[2]), .done_o(dn[2]));

   // Reference model: each instance owns a queue of future line levels,
   // one entry per clock cycle, plus a one-word holding slot.
   logic       lq [3][$];
   logic       hf [3] = '{1'b0, 1'b0, 1'b0};
   logic [8:0] held [3];
   int         acc_cnt [3] = '{0, 0, 0};

   function automatic int db(input int i);
      return (i == 1) ? 7 : 8;
   endfunction

   function automatic int pm(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
   endfunction

   function automatic int sb(input int i);
      return (i == 1) ? 2 : 1;
   endfunction

   function automatic void push_frame(input int i, input logic [8:0] w);
      logic p;
      p = 1'b0;
      repeat (CPB) lq[i].push_back(1'b0);
      for (int b = 0; b < db(i); b++) begin
         p = p ^ w[b];
         repeat (CPB) lq[i].push_back(w[b]);
      end
      if (pm(i) != 0) repeat (CPB) lq[i].push_back(p ^ (pm(i) == 2));
      repeat (sb(i) * CPB) lq[i].push_back(1'b1);
   endfunction

   always @(posedge clk or posedge rst) begin : mdl
      logic acc;
      logic wb;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            lq[i].delete();
            hf[i]   = 1'b0;
            held[i] = '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            acc = inv[i] && !hf[i];
            if (acc) acc_cnt[i]++;
            wb = (lq[i].size() > 0);
            if (wb) void'(lq[i].pop_front());
            if (lq[i].size() == 0 && hf[i]) begin
               push_frame(i, held[i]);
               hf[i] = 1'b0;
            end else if (wb && lq[i].size() == 0 && acc) begin
               push_frame(i, din[i]);
            end else if (acc) begin
               hf[i]   = 1'b1;
               held[i] = din[i];
            end
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[u%0d] at %0t: got %b want %b", nm, i, $time, act, exp);
      end
   endtask

   task automatic fail(input string nm, input int i);
      checks++;
      errors++;
      $display("FAIL %s[u%0d] at %0t: bound expired", nm, i, $time);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk("m_tx", i, tx[i], (lq[i].size() > 0) ? lq[i][0] : 1'b1);
         chk("m_busy", i, bsy[i], lq[i].size() > 0);
         chk("m_done", i, dn[i], lq[i].size() == 1);
         chk("m_ready", i, rdy[i], !hf[i]);
      end
   end

   task automatic wait_idle(input int i);
      int k;
      for (k = 0; k < 300; k++) begin
         if (lq[i].size() == 0 && !hf[i]) break;
         @(posedge clk);
         #1;
      end
      if (k == 300) fail("idle_timeout", i);
   endtask

   task automatic wait_done(input int i);
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (dn[i]) break;
      end
      if (k == 200) fail("done_timeout", i);
   endtask

   typedef struct {
      int         inst;
      logic [8:0] data;
      int         nbits;
      logic [15:0] bits;
   } vec_t;

   vec_t vt [9];

   task automatic send_vec(input vec_t v);
      int i;
      i = v.inst;
      wait_idle(i);
      @(posedge clk);
      #1;
      inv[i] = 1'b1;
      din[i] = v.data;
      @(posedge clk);
      #1;
      inv[i] = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= v.nbits * CPB; c++) begin
         @(negedge clk);
         if (c % CPB == CPB / 2) chk("vec_bit", i, tx[i], v.bits[(c - 1) / CPB]);
         chk("vec_done", i, dn[i], c == v.nbits * CPB);
         chk("vec_busy", i, bsy[i], 1'b1);
      end
      @(negedge clk);
      chk("vec_idle", i, bsy[i], 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      vt[0] = '{0, 9'h0A5, 10, 16'h034A};
      vt[1] = '{0, 9'h0FF, 10, 16'h03FE};
      vt[2] = '{0, 9'h000, 10, 16'h0200};
      vt[3] = '{2, 9'h0A5, 11, 16'h054A};
      vt[4] = '{2, 9'h000, 11, 16'h0400};
      vt[5] = '{2, 9'h001, 11, 16'h0602};
      vt[6] = '{1, 9'h07F, 11, 16'h06FE};
      vt[7] = '{1, 9'h000, 11, 16'h0700};
      vt[8] = '{1, 9'h055, 11, 16'h07AA};

      rst = 1'b1;
      inv = '0;
      for (int i = 0; i < 3; i++) din[i] = '0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_tx", i, tx[i], 1'b1);
         chk("rst_busy", i, bsy[i], 1'b0);
         chk("rst_done", i, dn[i], 1'b0);
         chk("rst_ready", i, rdy[i], 1'b1);
      end
      rst = 1'b0;

      for (int n = 0; n < 9; n++) send_vec(vt[n]);

      // two words back to back with in_valid held
      wait_idle(1);
      base = acc_cnt[1];
      @(posedge clk);
      #1;
      inv[1] = 1'b1;
      din[1] = 9'h07F;
      @(posedge clk);
      #1;
      din[1] = 9'h000;
      for (int k = 0; k < 100; k++) begin
         if (acc_cnt[1] >= base + 2) break;
         @(posedge clk);
         #1;
      end
      inv[1] = 1'b0;
      chk("held_ready", 1, rdy[1], 1'b0);
      wait_done(1);
      chk("held_ready_done", 1, rdy[1], 1'b0);
      @(negedge clk);
      chk("b2b_start", 1, tx[1], 1'b0);
      chk("b2b_busy", 1, bsy[1], 1'b1);
      wait_idle(1);

      // word offered on the very edge the last stop bit ends
      wait_idle(0);
      @(posedge clk);
      #1;
      inv[0] = 1'b1;
      din[0] = 9'h05A;
      @(posedge clk);
      #1;
      inv[0] = 1'b0;
      wait_done(0);
      inv[0] = 1'b1;
      din[0] = 9'h0C3;
      chk("edge_ready", 0, rdy[0], 1'b1);
      @(posedge clk);
      #1;
      inv[0] = 1'b0;
      @(negedge clk);
      chk("edge_start", 0, tx[0], 1'b0);
      chk("edge_busy", 0, bsy[0], 1'b1);
      wait_idle(0);

      // data churns while the holding register is full
      @(posedge clk);
      #1;
      inv[0] = 1'b1;
      din[0] = 9'h03C;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         din[0] = 9'($urandom);
      end
      inv[0] = 1'b0;
      wait_idle(0);

      // reset during data bit 3 with a second word held
      @(posedge clk);
      #1;
      inv[0] = 1'b1;
      din[0] = 9'h0A5;
      @(posedge clk);
      #1;
      din[0] = 9'h011;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      inv[0] = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      chk("pre_rst_bit3", 0, tx[0], 1'b0);
      chk("pre_rst_held", 0, rdy[0], 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_tx", 0, tx[0], 1'b1);
      chk("arst_busy", 0, bsy[0], 1'b0);
      chk("arst_done", 0, dn[0], 1'b0);
      chk("arst_ready", 0, rdy[0], 1'b1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("held_discarded", 0, bsy[0], 1'b0);
         chk("no_done", 0, dn[0], 1'b0);
      end
      send_vec(vt[0]);

      // random traffic on all three configurations
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            inv[i] = ($urandom_range(0, 3) == 0);
            din[i] = 9'($urandom);
         end
      end
      inv = '0;
      for (int i = 0; i < 3; i++) wait_idle(i);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
